// File: rtl/deser_8_32_sync.sv
// Framed byte-to-word receiver: acquires alignment from a run of sync bytes,
// then assembles MSB-first 32-bit words and aborts words stalled by long gaps.
module deser_8_32_sync #(
  parameter logic [7:0] SYNC_BYTE  = 8'hBC,
  parameter int         SYNC_COUNT = 4,
  parameter int         GAP_MAX    = 3
) (
  input  logic        clk,
  input  logic        reset_L,
  input  logic        valid_in,
  input  logic [7:0]  data_in,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        active,
  output logic        err,
  output logic [7:0]  word_cnt
);

  localparam logic [3:0] LP_SC = 4'(SYNC_COUNT);
  localparam logic [7:0] LP_GM = 8'(GAP_MAX);

  typedef enum logic [1:0] {ST_SYNC, ST_ALIGNED, ST_COLLECT} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_run;
  logic [7:0]  r_gap;
  logic [1:0]  r_idx;
  logic [31:0] r_stage;

  logic w_is_sync, w_run_done, w_abort, w_word_done, w_start;
  logic w_valid_nxt, w_err_nxt, w_active_nxt;

  assign w_is_sync   = valid_in && (data_in == SYNC_BYTE);
  assign w_run_done  = (r_state == ST_SYNC) && w_is_sync && ((r_run + 4'd1) == LP_SC);
  assign w_start     = (r_state == ST_ALIGNED) && valid_in && !w_is_sync;
  assign w_word_done = (r_state == ST_COLLECT) && valid_in && (r_idx == 2'd3);
  // gap counter already holds GAP_MAX idle cycles; this idle cycle is one too many
  assign w_abort     = (r_state == ST_COLLECT) && !valid_in && (r_gap == LP_GM);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) r_state <= ST_SYNC;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_SYNC:    if (w_run_done) w_next = ST_ALIGNED;
      ST_ALIGNED: if (w_start)    w_next = ST_COLLECT;
      ST_COLLECT: begin
        if (w_word_done)  w_next = ST_ALIGNED;
        else if (w_abort) w_next = ST_SYNC;
      end
      default:            w_next = ST_SYNC;
    endcase
  end

  always_comb begin
    w_valid_nxt  = w_word_done;
    w_err_nxt    = w_abort;
    w_active_nxt = (w_next != ST_SYNC);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_run     <= 4'd0;
      r_gap     <= 8'd0;
      r_idx     <= 2'd0;
      r_stage   <= 32'h0;
      data_out  <= 32'h0;
      valid_out <= 1'b0;
      active    <= 1'b0;
      err       <= 1'b0;
      word_cnt  <= 8'h0;
    end else begin
      valid_out <= w_valid_nxt;
      err       <= w_err_nxt;
      active    <= w_active_nxt;

      if (r_state == ST_SYNC) begin
        if (valid_in) r_run <= (w_is_sync && !w_run_done) ? r_run + 4'd1 : 4'd0;
      end else begin
        r_run <= 4'd0;
      end

      if (r_state == ST_COLLECT && !valid_in && !w_abort) r_gap <= r_gap + 8'd1;
      else                                                 r_gap <= 8'd0;

      if (w_start) begin
        r_stage[31:24] <= data_in;
        r_idx          <= 2'd1;
      end else if (r_state == ST_COLLECT && valid_in) begin
        case (r_idx)
          2'd1:    r_stage[23:16] <= data_in;
          2'd2:    r_stage[15:8]  <= data_in;
          default: r_stage[7:0]   <= data_in;
        endcase
        r_idx <= r_idx + 2'd1;
      end else if (w_abort) begin
        r_idx <= 2'd0;
      end

      if (w_word_done) begin
        data_out <= {r_stage[31:8], data_in};
        word_cnt <= word_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_deser_8_32_sync.sv
// Self-checking bench for deser_8_32_sync: table vectors, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_deser_8_32_sync;
  logic        clk = 1'b0;
  logic        reset_L = 1'b0;
  logic        valid_in = 1'b0;
  logic [7:0]  data_in = 8'h0;
  logic [31:0] data_out;
  logic        valid_out, active, err;
  logic [7:0]  word_cnt;

  deser_8_32_sync dut (
    .clk(clk), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out), .active(active),
    .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // reference model: alignment flag, run length, queue of collected bytes
  bit          m_aligned;
  int          m_run, m_gap;
  logic [7:0]  m_q[$];
  logic [31:0] m_do;
  bit          m_vo, m_err;
  logic [7:0]  m_cnt;

  task automatic model_reset();
    m_aligned = 0; m_run = 0; m_gap = 0; m_q.delete();
    m_do = 0; m_vo = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d);
    m_vo = 0; m_err = 0;
    if (!m_aligned) begin
      if (v) begin
        m_run = (d == 8'hBC) ? m_run + 1 : 0;
        if (m_run == 4) begin m_aligned = 1; m_run = 0; end
      end
    end else if (m_q.size() == 0) begin
      if (v && d != 8'hBC) m_q.push_back(d);
      m_gap = 0;
    end else if (v) begin
      m_gap = 0;
      m_q.push_back(d);
      if (m_q.size() == 4) begin
        m_do  = {m_q[0], m_q[1], m_q[2], m_q[3]};
        m_vo  = 1;
        m_cnt = m_cnt + 8'd1;
        m_q.delete();
      end
    end else begin
      m_gap++;
      if (m_gap > 3) begin
        m_err = 1; m_aligned = 0; m_q.delete(); m_run = 0; m_gap = 0;
      end
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d);
    @(negedge clk); valid_in = v; data_in = d;
    @(posedge clk); model_step(v, d);
    #1;
    chk("model.data_out",  data_out,  m_do);
    chk("model.valid_out", {31'h0, valid_out}, {31'h0, m_vo});
    chk("model.active",    {31'h0, active},    {31'h0, m_aligned});
    chk("model.err",       {31'h0, err},       {31'h0, m_err});
    chk("model.word_cnt",  {24'h0, word_cnt},  {24'h0, m_cnt});
  endtask

  task automatic do_reset();
    @(negedge clk); reset_L = 0; valid_in = 0;
    model_reset();
    @(negedge clk); reset_L = 1;
  endtask

  task automatic sync4();
    for (int i = 0; i < 4; i++) step(1, 8'hBC);
  endtask

  typedef struct {
    bit v; logic [7:0] d;
    bit e_act; bit e_vo; logic [31:0] e_do; logic [7:0] e_cnt;
  } vec_t;
  vec_t tbl[8];

  int pulses, last_pulse, cyc;
  logic [31:0] exp_w;

  initial begin
    tbl[0] = '{1, 8'hBC, 0, 0, 32'h0, 8'h0};
    tbl[1] = '{1, 8'hBC, 0, 0, 32'h0, 8'h0};
    tbl[2] = '{1, 8'hBC, 0, 0, 32'h0, 8'h0};
    tbl[3] = '{1, 8'hBC, 1, 0, 32'h0, 8'h0};
    tbl[4] = '{1, 8'hAA, 1, 0, 32'h0, 8'h0};
    tbl[5] = '{1, 8'hBB, 1, 0, 32'h0, 8'h0};
    tbl[6] = '{1, 8'hCC, 1, 0, 32'h0, 8'h0};
    tbl[7] = '{1, 8'hDD, 1, 1, 32'hAABBCCDD, 8'h1};

    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset.data_out", data_out, 32'h0);
    chk("reset.outs", {28'h0, valid_out, active, err, 1'b0}, 32'h0);
    chk("reset.word_cnt", {24'h0, word_cnt}, 32'h0);
    reset_L = 1;

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].d);
      chk("tbl.active",    {31'h0, active},    {31'h0, tbl[i].e_act});
      chk("tbl.valid_out", {31'h0, valid_out}, {31'h0, tbl[i].e_vo});
      chk("tbl.data_out",  data_out,           tbl[i].e_do);
      chk("tbl.word_cnt",  {24'h0, word_cnt},  {24'h0, tbl[i].e_cnt});
    end
    step(0, 8'h0);
    chk("vo.one_cycle", {31'h0, valid_out}, 32'h0);

    // broken sync run
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 8'hBC);
    step(1, 8'h00);
    for (int i = 0; i < 3; i++) step(1, 8'hBC);
    chk("broken_run.active", {31'h0, active}, 32'h0);
    step(1, 8'hBC);
    chk("second_run.active", {31'h0, active}, 32'h1);
    step(1, 8'h11); step(1, 8'h22); step(1, 8'h33); step(1, 8'h44);
    chk("second_run.data_out", data_out, 32'h11223344);

    // sync value mid-word
    step(1, 8'h01); step(1, 8'hBC); step(1, 8'h02); step(1, 8'h03);
    chk("midsync.data_out", data_out, 32'h01BC0203);

    // gap of GAP_MAX tolerated, GAP_MAX+1 aborts
    step(1, 8'h12); step(1, 8'h34);
    repeat (3) step(0, 8'h0);
    step(1, 8'h56); step(1, 8'h78);
    chk("gap3.data_out", data_out, 32'h12345678);
    chk("gap3.err", {31'h0, err}, 32'h0);
    chk("gap3.word_cnt", {24'h0, word_cnt}, 32'h3);
    step(1, 8'h12); step(1, 8'h34);
    repeat (3) step(0, 8'h0);
    chk("gap4.pre_err", {31'h0, err}, 32'h0);
    step(0, 8'h0);
    chk("gap4.err", {31'h0, err}, 32'h1);
    chk("gap4.active", {31'h0, active}, 32'h0);
    chk("gap4.data_out", data_out, 32'h12345678);
    chk("gap4.word_cnt", {24'h0, word_cnt}, 32'h3);
    step(0, 8'h0);
    chk("gap4.err_pulse", {31'h0, err}, 32'h0);

    // 256 back-to-back words
    do_reset();
    sync4();
    pulses = 0; last_pulse = -1;
    for (int w = 0; w < 256; w++) begin
      exp_w = {8'h5A, 24'($urandom)};
      for (int b = 0; b < 4; b++) begin
        step(1, exp_w[31-8*b -: 8]);
        cyc = w * 4 + b;
        if (valid_out) begin
          if (last_pulse >= 0) chk("b2b.spacing", 32'(cyc - last_pulse), 32'd4);
          last_pulse = cyc; pulses++;
        end
      end
      chk("b2b.word", data_out, exp_w);
    end
    chk("b2b.pulses", 32'(pulses), 32'd256);
    chk("b2b.wrap", {24'h0, word_cnt}, 32'h0);

    // reset mid-word
    step(1, 8'hA1); step(1, 8'hA2); step(1, 8'hA3);
    @(negedge clk); reset_L = 0; #1;
    chk("midrst.data_out", data_out, 32'h0);
    chk("midrst.outs", {29'h0, valid_out, active, err}, 32'h0);
    chk("midrst.word_cnt", {24'h0, word_cnt}, 32'h0);
    model_reset();
    @(negedge clk); reset_L = 1;
    step(1, 8'hA4); step(1, 8'hAA); step(1, 8'hBB); step(1, 8'hCC); step(1, 8'hDD);
    chk("midrst.ignored", {31'h0, active}, 32'h0);
    sync4();
    step(1, 8'h21); step(1, 8'h22); step(1, 8'h23); step(1, 8'h24);
    chk("midrst.recover", data_out, 32'h21222324);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      int r;
      r = $urandom_range(0, 15);
      if (r < 2) repeat ($urandom_range(1, 5)) step(0, 8'($urandom));
      else if (r < 8) step(1, 8'hBC);
      else step(1, 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/deser_8_32_sync.md
# deser_8_32_sync

Framed byte-to-word receiver. It sits at the far end of the 8-bit link driven by the 32→8 serializer. It acquires alignment from a run of idle sync bytes, then rebuilds 32-bit words MSB-first from valid-qualified bytes. It also flags gaps that would corrupt a word in progress and counts good words.

## Interface
- SYNC_BYTE, 8'hBC: idle/alignment byte value.
- SYNC_COUNT, 4: consecutive valid SYNC_BYTEs needed to declare alignment (range 1..15).
- GAP_MAX, 3: max consecutive cycles with valid_in low allowed inside a word (range 1..255).
- clk  in  1  single clock; all logic on its rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- valid_in  in  1  data_in carries a byte this cycle.
- data_in  in  8  received byte.
- data_out  out  32  last completed word; byte 0 is in [31:24].
- valid_out  out  1  one-cycle pulse when data_out updates.
- active  out  1  high while aligned (ALIGNED or COLLECT).
- err  out  1  one-cycle pulse on word abort.
- word_cnt  out  8  completed-word counter; wraps 255→0.

## Operation
- States: SYNC, ALIGNED, COLLECT. Byte index idx is 2 bits. Sync run counter is 4 bits. Gap counter is 8 bits.
- SYNC
  - A valid byte equal to SYNC_BYTE increments the run counter.
  - A valid byte not equal to SYNC_BYTE clears the run counter.
  - valid_in low leaves the run counter unchanged.
  - When the run counter reaches SYNC_COUNT, move to ALIGNED.
- ALIGNED
  - Valid SYNC_BYTE is idle; stay in ALIGNED.
  - A valid non-sync byte goes to data_out staging [31:24]. Set idx=1 and go to COLLECT.
  - Consequence: an upstream word must not have MSB == SYNC_BYTE.
- COLLECT
  - Every valid byte is data, including SYNC_BYTE values.
  - Bytes 1, 2, 3 go to staging [23:16], [15:8], [7:0] in that order.
  - On byte 3: copy staging to data_out, pulse valid_out, increment word_cnt, return to ALIGNED.
- Gap rule (COLLECT only)
  - The gap counter counts consecutive cycles with valid_in low and clears on any valid byte.
  - When it reaches GAP_MAX+1, abort: pulse err, drop the partial word, go to SYNC with the run counter cleared.
  - data_out and word_cnt are unchanged on abort.
- Staging is an internal register. data_out changes only on a completed word.
- active = (state != SYNC).

## Timing
- All outputs are registered.
- Reset values: data_out=32'h0, valid_out=0, active=0, err=0, word_cnt=8'h0, state=SYNC, all internal counters 0.
- Asserting reset_L low forces these values immediately, mid-word included. Any partial word is lost.
- Acquisition latency
  - The SYNC_COUNT-th sync byte is sampled at edge N; active is high after edge N.
  - A data byte at edge N+1 is accepted as byte 0.
- Word latency
  - Byte 3 is sampled at edge N; data_out and valid_out are valid after edge N.
  - valid_out drops after edge N+1 unless another word completes on that edge.
- Back-to-back words without idle bytes are supported.
  - Byte 0 of the next word may arrive the cycle after byte 3. One word per 4 valid cycles is sustained.
- Gap abort
  - The last valid byte is at edge N and valid_in stays low.
  - err pulses after edge N+GAP_MAX+1 and active drops on the same edge.
- A valid byte arriving on the abort edge is not possible: the gap counter clears first.
- word_cnt wrap: word 256 after reset reads 8'h00 and valid_out still pulses.

## Test plan
- Reset, then 4×BC, then AA BB CC DD all valid → active high after 4th BC; data_out=32'hAABBCCDD, valid_out one cycle, word_cnt=1.
- 3×BC, one 8'h00, 4×BC, then 11 22 33 44 → no alignment until the second BC run; data_out=32'h11223344.
- Aligned, then 01 BC 02 03 → data_out=32'h01BC0203 (sync value accepted mid-word).
- Aligned, then 12 34, valid low 3 cycles, 56 78 → data_out=32'h12345678, err=0. Repeat with valid low 4 cycles → err pulse, active=0, data_out and word_cnt unchanged.
- Aligned, then 256 back-to-back words, 1024 consecutive valid bytes → 256 valid_out pulses spaced 4 cycles apart; word_cnt=8'h00.
- reset_L low for 1 cycle after byte 2 of a word → outputs immediately reset; after release, bytes are ignored until a fresh 4×BC run.
